// File: rtl/reg_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
// One owner at a time; ownership rotates after MAX_BURST writes under contention.
module reg_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   d,
   input  logic                    clr,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         ack,
   output logic [WIDTH-1:0]        q,
   output logic                    q_valid,
   output logic                    busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned BW = $clog2(MAX_BURST) + 1;

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t           r_state;
   logic [NREQ-1:0]  r_grant;
   logic [NREQ-1:0]  r_ack;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_owner;
   logic [BW-1:0]    r_burst;

   logic [PW-1:0]    w_idx;
   logic [PW-1:0]    w_sel;
   logic             w_found;
   logic [NREQ-1:0]  w_sel_oh;
   logic [WIDTH-1:0] w_odata;
   logic [PW-1:0]    w_next_ptr;
   logic             w_own_req;
   logic             w_last;
   logic             w_others;

   // First set request scanning upward from r_ptr, wrapping modulo NREQ.
   always_comb begin
      w_idx   = '0;
      w_sel   = r_ptr;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_idx = PW'((32'(r_ptr) + k) % NREQ);
         if (!w_found && req[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_odata = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (r_owner == PW'(i)) w_odata = d[i*WIDTH +: WIDTH];
      end
   end

   assign w_sel_oh   = NREQ'(1) << w_sel;
   assign w_next_ptr = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
   assign w_own_req  = req[r_owner];
   assign w_last     = (r_burst == BW'(MAX_BURST-1));
   assign w_others   = |(req & ~r_grant);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_ack     <= '0;
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_burst   <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_grant <= w_sel_oh;
                  r_owner <= w_sel;
                  r_burst <= '0;
                  r_state <= S_OWN;
               end
            end
            S_OWN: begin
               if (w_own_req) begin
                  // A cleared cycle is not a write: burst count and rotation hold.
                  if (!clr) begin
                     r_q       <= w_odata;
                     r_q_valid <= 1'b1;
                     r_ack     <= r_grant;
                     if (w_last && w_others) begin
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_burst <= '0;
                        r_state <= S_IDLE;
                     end else if (w_last) begin
                        r_burst <= '0;
                     end else begin
                        r_burst <= r_burst + 1'b1;
                     end
                  end
               end else begin
                  r_grant <= '0;
                  r_ptr   <= w_next_ptr;
                  r_burst <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (clr) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
         end
      end
   end

   assign grant   = r_grant;
   assign ack     = r_ack;
   assign q       = r_q;
   assign q_valid = r_q_valid;
   assign busy    = |r_grant;

endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboarded bench for reg_arbiter: a cycle model pushes expected outputs
// as stimulus is applied; each task pops and compares after the clock edge.
module tb_reg_arbiter;

   localparam int NREQ = 4;
   localparam int WIDTH = 8;
   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] d;
   logic        clr;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic [7:0]  q;
   logic        q_valid;
   logic        busy;

   reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req(req), .d(d), .clr(clr),
      .grant(grant), .ack(ack), .q(q), .q_valid(q_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   logic [17:0] sb[$];
   logic [17:0] exp_v;

   bit         m_own;
   int         m_ptr, m_owner, m_cnt;
   logic [3:0] m_grant, m_ack;
   logic [7:0] m_q;
   logic       m_qv;

   task automatic model_reset();
      m_own = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      m_grant = '0; m_ack = '0; m_q = '0; m_qv = 1'b0;
   endtask

   task automatic model_step();
      bit rel = 0;
      m_ack = '0;
      if (!m_own) begin
         if (req != 4'b0) begin
            for (int k = 0; k < NREQ; k++) begin
               int idx = (m_ptr + k) % NREQ;
               if (req[idx]) begin
                  m_owner = idx; m_grant = 4'(1 << idx); m_cnt = 0; m_own = 1;
                  break;
               end
            end
         end
      end else if (!req[m_owner]) begin
         rel = 1;
      end else if (!clr) begin
         m_q = d[m_owner*WIDTH +: WIDTH]; m_qv = 1'b1; m_ack = m_grant;
         if (m_cnt == MB-1) begin
            if ((req & ~m_grant) != 4'b0) rel = 1;
            else m_cnt = 0;
         end else m_cnt++;
      end
      if (rel) begin
         m_grant = '0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0; m_own = 0;
      end
      if (clr) begin
         m_q = '0; m_qv = 1'b0; m_ack = '0;
      end
   endtask

   task automatic tick();
      model_step();
      sb.push_back({m_grant, m_ack, m_q, m_qv, |m_grant});
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; req = '0; clr = 1'b0;
      model_reset();
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; clr = 1'b0; d = '0;
      #1;
      nvec++;
      if ({grant, ack, q, q_valid, busy} !== 18'h0) begin
         nerr++; $display("FAIL reset: got %h want %h", {grant, ack, q, q_valid, busy}, 18'h0);
      end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      d = 32'h0000_A500; req = 4'b0010;
      tick(); exp_v = sb.pop_front(); nvec++;
      if ({grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL single_arb_model: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
      nvec++;
      if (grant !== 4'b0010 || ack !== 4'b0) begin nerr++; $display("FAIL single_arb: grant %b ack %b want 0010 0000", grant, ack); end
      tick(); exp_v = sb.pop_front(); nvec++;
      if ({grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL single_w1_model: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
      nvec++;
      if (q !== 8'hA5 || ack !== 4'b0010 || q_valid !== 1'b1) begin nerr++; $display("FAIL single_w1: q %h ack %b qv %b want a5 0010 1", q, ack, q_valid); end
      repeat (6) begin
         tick(); exp_v = sb.pop_front(); nvec++;
         if (grant !== 4'b0010 || ack !== 4'b0010 || {grant, ack, q, q_valid, busy} !== exp_v) begin
            nerr++; $display("FAIL single_hold: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v);
         end
      end
      req = '0;
      repeat (2) begin
         tick(); exp_v = sb.pop_front(); nvec++;
         if ({grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL single_release: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
      end
   endtask

   task automatic test_contention();
      int na0 = 0, na2 = 0;
      apply_reset();
      d = 32'h4433_2211; req = 4'b0101;
      for (int t = 1; t <= 20; t++) begin
         tick(); exp_v = sb.pop_front(); nvec++;
         if ({grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL contention_t%0d: got %h want %h", t, {grant, ack, q, q_valid, busy}, exp_v); end
         if (ack[0]) na0++;
         if (ack[2]) na2++;
         if (t == 5 || t == 6 || t == 11) begin
            nvec++;
            if (grant !== ((t == 5) ? 4'b0000 : (t == 6) ? 4'b0100 : 4'b0001)) begin
               nerr++; $display("FAIL contention_grant_t%0d: got %b", t, grant);
            end
         end
      end
      nvec++;
      if (na0 != 8 || na2 != 8) begin nerr++; $display("FAIL contention_counts: ack0 %0d ack2 %0d want 8 8", na0, na2); end
   endtask

   task automatic test_early_release();
      logic [3:0] want;
      apply_reset();
      d = 32'h4433_2211; req = 4'b1100;
      for (int t = 1; t <= 9; t++) begin
         if (t == 4) req = 4'b1000;
         if (t == 8) req = 4'b0001;
         tick(); exp_v = sb.pop_front(); nvec++;
         if ({grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL early_t%0d: got %h want %h", t, {grant, ack, q, q_valid, busy}, exp_v); end
         want = (t <= 3) ? 4'b0100 : (t == 4 || t == 8) ? 4'b0000 : (t == 9) ? 4'b0001 : 4'b1000;
         nvec++;
         if (grant !== want) begin nerr++; $display("FAIL early_grant_t%0d: got %b want %b", t, grant, want); end
      end
   endtask

   task automatic test_clr();
      apply_reset();
      d = 32'h4433_2211; req = 4'b0011;
      tick(); void'(sb.pop_front());
      tick(); exp_v = sb.pop_front(); nvec++;
      if (q !== 8'h11 || ack !== 4'b0001 || {grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL clr_w1: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
      clr = 1'b1;
      tick(); exp_v = sb.pop_front(); nvec++;
      if (q !== 8'h00 || q_valid !== 1'b0 || ack !== 4'b0 || grant !== 4'b0001 || {grant, ack, q, q_valid, busy} !== exp_v) begin
         nerr++; $display("FAIL clr_cycle: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v);
      end
      clr = 1'b0;
      tick(); exp_v = sb.pop_front(); nvec++;
      if (q !== 8'h11 || ack !== 4'b0001 || q_valid !== 1'b1) begin nerr++; $display("FAIL clr_after: q %h ack %b qv %b want 11 0001 1", q, ack, q_valid); end
      tick(); exp_v = sb.pop_front(); nvec++;
      if (grant !== 4'b0001 || {grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL clr_w3: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
      tick(); exp_v = sb.pop_front(); nvec++;
      if (grant !== 4'b0000 || ack !== 4'b0001 || {grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL clr_w4_rotate: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      d = 32'h4433_2211; req = 4'b0100;
      tick(); void'(sb.pop_front());
      tick(); exp_v = sb.pop_front(); nvec++;
      if (grant !== 4'b0100 || ack !== 4'b0100 || {grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL async_pre: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
      #2 rst = 1'b0;
      #1;
      nvec++;
      if ({grant, ack, q, q_valid, busy} !== 18'h0) begin nerr++; $display("FAIL async_clear: got %h want %h", {grant, ack, q, q_valid, busy}, 18'h0); end
      model_reset();
      req = 4'b0101;
      #1 rst = 1'b1;
      tick(); exp_v = sb.pop_front(); nvec++;
      if (grant !== 4'b0001 || {grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL async_rearb: got %h want %h", {grant, ack, q, q_valid, busy}, exp_v); end
   endtask

   task automatic test_all_req();
      logic [3:0] order[$];
      logic [3:0] want_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] prev = '0;
      int nack[4] = '{0, 0, 0, 0};
      apply_reset();
      d = 32'hD4C3_B2A1; req = 4'b1111;
      for (int t = 1; t <= 25; t++) begin
         tick(); exp_v = sb.pop_front(); nvec++;
         if ({grant, ack, q, q_valid, busy} !== exp_v) begin nerr++; $display("FAIL all_t%0d: got %h want %h", t, {grant, ack, q, q_valid, busy}, exp_v); end
         nvec++;
         if ($countones(ack) > 1) begin nerr++; $display("FAIL all_ack_onehot_t%0d: got %b", t, ack); end
         if (grant != 4'b0 && prev == 4'b0) order.push_back(grant);
         prev = grant;
         for (int i = 0; i < 4; i++) if (ack[i]) nack[i]++;
      end
      nvec++;
      if (order.size() != 5) begin nerr++; $display("FAIL all_order_len: got %0d want 5", order.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            nvec++;
            if (order[i] !== want_order[i]) begin nerr++; $display("FAIL all_order_%0d: got %b want %b", i, order[i], want_order[i]); end
         end
      end
      nvec++;
      if (nack[0] != 2*MB || nack[1] != MB || nack[2] != MB || nack[3] != MB) begin
         nerr++; $display("FAIL all_burst_counts: got %0d %0d %0d %0d want 8 4 4 4", nack[0], nack[1], nack[2], nack[3]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_early_release();
      test_clr();
      test_async_reset();
      test_all_req();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
